// File: rtl/eb_fifo.sv
// eb_fifo: DEPTH-entry valid/ready elastic buffer with occupancy output.
// Ready and valid come straight from flops and never depend on the
// opposite side of the handshake in the same cycle.
// Optional feature macro: EB_FIFO_BYPASS_EN (fall-through when empty).
module eb_fifo #(
  parameter int T_0_WIDTH = 8,
  parameter int I_0_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [T_0_WIDTH-1:0]         t_0_data,
  input  logic                         t_0_valid,
  output logic                         t_0_ready,
  output logic [I_0_WIDTH-1:0]         i_0_data,
  output logic                         i_0_valid,
  input  logic                         i_0_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EXT_W = (T_0_WIDTH > I_0_WIDTH) ? T_0_WIDTH : I_0_WIDTH;

  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_C = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] FIRST_C = {PTR_W{1'b0}};

  // Wider output: zero-extend the MSBs; narrower output: keep the LSBs.
  function automatic logic [I_0_WIDTH-1:0] map_width(input logic [T_0_WIDTH-1:0] d);
    logic [EXT_W-1:0] ext;
    ext = {EXT_W{1'b0}};
    ext[T_0_WIDTH-1:0] = d;
    return ext[I_0_WIDTH-1:0];
  endfunction

  // Explicit wrap at DEPTH-1 so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == LAST_C) begin
      n = FIRST_C;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  logic [T_0_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 ready_r;
  logic                 valid_r;

  logic                 push_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [CNT_W-1:0]     count_nxt_s;
  logic [I_0_WIDTH-1:0] data_s;

  assign t_0_ready = ready_r;
  assign count     = count_r;
  assign i_0_data  = data_s;

`ifdef EB_FIFO_BYPASS_EN
  logic pass_s;

  assign i_0_valid = valid_r | t_0_valid;

  // Handshake decode: an empty buffer hands an accepted word straight through.
  always_comb begin
    push_s  = t_0_valid & ready_r;
    pass_s  = ~valid_r & push_s & i_0_ready;
    wr_en_s = push_s & ~pass_s;
    rd_en_s = valid_r & i_0_ready;
    if (valid_r) begin
      data_s = map_width(mem_r[rd_ptr_r]);
    end else begin
      data_s = map_width(t_0_data);
    end
  end
`else
  assign i_0_valid = valid_r;

  // Handshake decode: transfers only on valid & ready, output from storage.
  always_comb begin
    push_s  = t_0_valid & ready_r;
    wr_en_s = push_s;
    rd_en_s = valid_r & i_0_ready;
    data_s  = map_width(mem_r[rd_ptr_r]);
  end
`endif

  // Occupancy update: simultaneous write and read leave the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // State registers; ready/valid are precomputed from the next count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {T_0_WIDTH{1'b0}};
      end
      wr_ptr_r <= FIRST_C;
      rd_ptr_r <= FIRST_C;
      count_r  <= EMPTY_C;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != FULL_C);
      valid_r <= (count_nxt_s != EMPTY_C);
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= t_0_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (rd_en_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
    end
  end

endmodule

// File: tb/tb_eb_fifo.sv
// Self-checking bench for eb_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against queue-based models.
module tb_eb_fifo;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DEPTH 4, 8 -> 8
  logic [7:0]  a_td;  logic a_tv, a_tr, a_iv, a_ir;  logic [7:0]  a_id;  logic [2:0] a_cnt;
  // DUT B: DEPTH 3, 8 -> 12 (zero extend)
  logic [7:0]  b_td;  logic b_tv, b_tr, b_iv, b_ir;  logic [11:0] b_id;  logic [1:0] b_cnt;
  // DUT C: DEPTH 1, 8 -> 4 (truncate)
  logic [7:0]  c_td;  logic c_tv, c_tr, c_iv, c_ir;  logic [3:0]  c_id;  logic [0:0] c_cnt;

  eb_fifo #(.T_0_WIDTH(8), .I_0_WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .t_0_data(a_td), .t_0_valid(a_tv), .t_0_ready(a_tr),
    .i_0_data(a_id), .i_0_valid(a_iv), .i_0_ready(a_ir), .count(a_cnt));
  eb_fifo #(.T_0_WIDTH(8), .I_0_WIDTH(12), .DEPTH(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .t_0_data(b_td), .t_0_valid(b_tv), .t_0_ready(b_tr),
    .i_0_data(b_id), .i_0_valid(b_iv), .i_0_ready(b_ir), .count(b_cnt));
  eb_fifo #(.T_0_WIDTH(8), .I_0_WIDTH(4), .DEPTH(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .t_0_data(c_td), .t_0_valid(c_tv), .t_0_ready(c_tr),
    .i_0_data(c_id), .i_0_valid(c_iv), .i_0_ready(c_ir), .count(c_cnt));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic tv; int td; logic ir;
    int ecount; logic eready; logic evalid; int edata;
  } vec_t;

  vec_t vecs[10];
  int qa[$];
  int qb[$];

  initial begin
    int ev, ed, k;
    logic push, pop;

    a_tv = 1'b0; a_td = 8'h00; a_ir = 1'b0;
    b_tv = 1'b0; b_td = 8'h00; b_ir = 1'b0;
    c_tv = 1'b0; c_td = 8'h00; c_ir = 1'b0;

    // fill then drain DEPTH 4; full + pop-only; push accepted the cycle after
    vecs[0] = '{1'b1, 'h11, 1'b0, 1, 1'b1, 1'b1, 'h11};
    vecs[1] = '{1'b1, 'h22, 1'b0, 2, 1'b1, 1'b1, 'h11};
    vecs[2] = '{1'b1, 'h33, 1'b0, 3, 1'b1, 1'b1, 'h11};
    vecs[3] = '{1'b1, 'h44, 1'b0, 4, 1'b0, 1'b1, 'h11};
    vecs[4] = '{1'b1, 'h55, 1'b1, 3, 1'b1, 1'b1, 'h22};
    vecs[5] = '{1'b1, 'h55, 1'b0, 4, 1'b0, 1'b1, 'h22};
    vecs[6] = '{1'b0, 'h00, 1'b1, 3, 1'b1, 1'b1, 'h33};
    vecs[7] = '{1'b0, 'h00, 1'b1, 2, 1'b1, 1'b1, 'h44};
    vecs[8] = '{1'b0, 'h00, 1'b1, 1, 1'b1, 1'b1, 'h55};
    vecs[9] = '{1'b0, 'h00, 1'b1, 0, 1'b1, 1'b0, 'h00};

    // ---- reset state
    #12;
    check("rst_a_count", int'(a_cnt), 0);
    check("rst_a_ready", int'(a_tr), 1);
    check("rst_a_valid", int'(a_iv), 0);
    check("rst_a_data",  int'(a_id), 0);
    check("rst_b_data",  int'(b_id), 0);
    check("rst_c_ready", int'(c_tr), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- directed table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_tv = vecs[i].tv; a_td = 8'(vecs[i].td); a_ir = vecs[i].ir;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), int'(a_cnt), vecs[i].ecount);
      check($sformatf("vec%0d_ready", i), int'(a_tr), int'(vecs[i].eready));
      check($sformatf("vec%0d_valid", i), int'(a_iv), int'(vecs[i].evalid));
      if (vecs[i].evalid) check($sformatf("vec%0d_data", i), int'(a_id), vecs[i].edata);
    end

    // ---- continuous push+pop, 100 words, one per cycle
    @(negedge clk);
    a_tv = 1'b1; a_td = 8'd0; a_ir = 1'b0;
    @(posedge clk);
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      a_tv = 1'b1; a_td = 8'(k); a_ir = 1'b1;
      #1;
      check("stream_valid", int'(a_iv), 1);
      check("stream_data", int'(a_id), (k - 1) % 256);
      @(posedge clk);
      #1;
      check("stream_count", int'(a_cnt), 1);
    end

    // ---- async reset mid-cycle with count=2
    @(negedge clk);
    a_tv = 1'b1; a_td = 8'hC3; a_ir = 1'b0;
    @(posedge clk);
    #1;
    check("prerst_count", int'(a_cnt), 2);
    @(negedge clk);
    a_tv = 1'b0; a_td = 8'h00;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_count", int'(a_cnt), 0);
    check("midrst_valid", int'(a_iv), 0);
    check("midrst_ready", int'(a_tr), 1);
    check("midrst_data",  int'(a_id), 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef EB_FIFO_BYPASS_EN
    // ---- fall-through when empty
    @(negedge clk);
    a_tv = 1'b1; a_td = 8'hA5; a_ir = 1'b1;
    #1;
    check("byp_valid", int'(a_iv), 1);
    check("byp_data",  int'(a_id), 'hA5);
    check("byp_count0", int'(a_cnt), 0);
    @(posedge clk);
    #1;
    check("byp_count1", int'(a_cnt), 0);
    @(negedge clk);
    a_tv = 1'b0; a_ir = 1'b0;
`endif

    // ---- width mapping and DEPTH=1 full behaviour
    @(negedge clk);
    b_tv = 1'b1; b_td = 8'hFF; b_ir = 1'b0;
    c_tv = 1'b1; c_td = 8'hFF; c_ir = 1'b0;
    @(posedge clk);
    #1;
    check("wid12_data", int'(b_id), 'h0FF);
    check("wid4_data",  int'(c_id), 'hF);
    check("d1_count",   int'(c_cnt), 1);
    check("d1_ready",   int'(c_tr), 0);
    @(negedge clk);
    b_tv = 1'b0; b_ir = 1'b1;
    c_td = 8'h3C; c_ir = 1'b1;
    @(posedge clk);
    #1;
    check("d1_poponly_count", int'(c_cnt), 0);
    check("d1_poponly_ready", int'(c_tr), 1);
    check("wid12_drained", int'(b_cnt), 0);
    @(negedge clk);
    c_tv = 1'b0; c_ir = 1'b0; b_ir = 1'b0;

    // ---- randomized traffic vs queue models (A: DEPTH 4, B: DEPTH 3 wraps)
    qa.delete(); qb.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      a_tv = ($urandom_range(0, 3) != 0); a_td = 8'($urandom_range(0, 255)); a_ir = ($urandom_range(0, 2) != 0);
      b_tv = ($urandom_range(0, 2) != 0); b_td = 8'($urandom_range(0, 255)); b_ir = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
      #1;
      // model A
      check("rnd_a_count", int'(a_cnt), qa.size());
      check("rnd_a_ready", int'(a_tr), (qa.size() != 4) ? 1 : 0);
`ifdef EB_FIFO_BYPASS_EN
      ev = (qa.size() != 0 || a_tv) ? 1 : 0;
      ed = (qa.size() != 0) ? qa[0] : int'(a_td);
`else
      ev = (qa.size() != 0) ? 1 : 0;
      ed = (qa.size() != 0) ? qa[0] : 0;
`endif
      check("rnd_a_valid", int'(a_iv), ev);
      if (ev != 0) check("rnd_a_data", int'(a_id), ed);
      push = a_tv && (qa.size() != 4);
      pop  = (ev != 0) && a_ir;
      // model B (output is the 8-bit word zero-extended to 12 bits)
      check("rnd_b_count", int'(b_cnt), qb.size());
      check("rnd_b_ready", int'(b_tr), (qb.size() != 3) ? 1 : 0);
`ifdef EB_FIFO_BYPASS_EN
      ev = (qb.size() != 0 || b_tv) ? 1 : 0;
      ed = (qb.size() != 0) ? qb[0] : int'(b_td);
`else
      ev = (qb.size() != 0) ? 1 : 0;
      ed = (qb.size() != 0) ? qb[0] : 0;
`endif
      check("rnd_b_valid", int'(b_iv), ev);
      if (ev != 0) check("rnd_b_data", int'(b_id), ed);
      @(posedge clk);
      // advance model A
`ifdef EB_FIFO_BYPASS_EN
      if (!(qa.size() == 0 && push && a_ir)) begin
`else
      begin
`endif
        if (pop) void'(qa.pop_front());
        if (push) qa.push_back(int'(a_td));
      end
      // advance model B
      push = b_tv && (qb.size() != 3);
      pop  = (qb.size() != 0) && b_ir;
`ifdef EB_FIFO_BYPASS_EN
      if (!(qb.size() == 0 && push && b_ir)) begin
`else
      begin
`endif
        if (pop) void'(qb.pop_front());
        if (push) qb.push_back(int'(b_td));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
